// File: rtl/rs485_tx.sv
// RS485 byte transmitter: one-entry holding buffer, 8N1 UART framing, DE setup/hold guard times.
// Define RS485_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module rs485_tx #(
   parameter int unsigned CLK_FREQ      = 50_000_000,
   parameter int unsigned BAUD          = 115_200,
   parameter int unsigned DE_SETUP_CLKS = 16,
   parameter int unsigned DE_HOLD_CLKS  = 16
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_out,
   output logic       rs485_de,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int unsigned BAUD_CNT   = CLK_FREQ / BAUD;
   localparam int unsigned MAX_A      = (BAUD_CNT > DE_SETUP_CLKS) ? BAUD_CNT : DE_SETUP_CLKS;
   localparam int unsigned MAX_CNT    = (MAX_A > DE_HOLD_CLKS) ? MAX_A : DE_HOLD_CLKS;
   localparam int unsigned CNT_W      = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;
   localparam int unsigned BAUD_LAST  = BAUD_CNT - 1;
   localparam int unsigned DONE_AT    = BAUD_CNT - 2;
   localparam int unsigned SETUP_LAST = (DE_SETUP_CLKS > 0) ? DE_SETUP_CLKS - 1 : 0;
   localparam int unsigned HOLD_LAST  = (DE_HOLD_CLKS > 0) ? DE_HOLD_CLKS - 1 : 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_START,
      S_DATA,
`ifdef RS485_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_HOLD
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_cnt;
   logic [7:0]       shreg;
   logic [7:0]       hold_byte;
   logic             buf_full;
`ifdef RS485_TX_PARITY_EN
   logic             parity;
`endif

   logic baud_last_c;
   logic accept_c;
   logic load_c;

   // Buffer hands its byte to the shifter from IDLE, HOLD, or the last cycle of STOP.
   always_comb begin
      baud_last_c = (cnt == CNT_W'(BAUD_LAST));
      accept_c    = tx_valid & tx_ready;
      load_c      = buf_full & ((state == S_IDLE) | (state == S_HOLD) |
                                ((state == S_STOP) & baud_last_c));
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         hold_byte <= '0;
         buf_full  <= 1'b0;
         tx_ready  <= 1'b0;
         tx_out    <= 1'b1;
         rs485_de  <= 1'b0;
         tx_busy   <= 1'b0;
         tx_done   <= 1'b0;
`ifdef RS485_TX_PARITY_EN
         parity    <= 1'b0;
`endif
      end else begin
         tx_done <= 1'b0;

         // Accept and load are mutually exclusive: accept needs an empty buffer, load a full one.
         if (accept_c) begin
            buf_full  <= 1'b1;
            hold_byte <= tx_data;
         end else if (load_c) begin
            buf_full <= 1'b0;
         end
         tx_ready <= ~(accept_c | (buf_full & ~load_c));

         if (load_c) begin
            shreg <= hold_byte;
`ifdef RS485_TX_PARITY_EN
            parity <= ^hold_byte;
`endif
         end

         case (state)
            S_IDLE: begin
               if (load_c) begin
                  rs485_de <= 1'b1;
                  tx_busy  <= 1'b1;
                  cnt      <= '0;
                  if (DE_SETUP_CLKS == 0) begin
                     state  <= S_START;
                     tx_out <= 1'b0;
                  end else begin
                     state <= S_SETUP;
                  end
               end
            end

            S_SETUP: begin
               if (cnt == CNT_W'(SETUP_LAST)) begin
                  state  <= S_START;
                  cnt    <= '0;
                  tx_out <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            S_START: begin
               if (baud_last_c) begin
                  state   <= S_DATA;
                  cnt     <= '0;
                  bit_cnt <= '0;
                  tx_out  <= shreg[0];
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            S_DATA: begin
               if (baud_last_c) begin
                  cnt <= '0;
                  if (bit_cnt == 3'd7) begin
`ifdef RS485_TX_PARITY_EN
                     state  <= S_PARITY;
                     tx_out <= parity;
`else
                     state  <= S_STOP;
                     tx_out <= 1'b1;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     shreg   <= shreg >> 1;
                     tx_out  <= shreg[1];
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

`ifdef RS485_TX_PARITY_EN
            S_PARITY: begin
               if (baud_last_c) begin
                  state  <= S_STOP;
                  cnt    <= '0;
                  tx_out <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
`endif

            S_STOP: begin
               // tx_done is registered, so it is raised one edge ahead of the final stop cycle.
               if (cnt == CNT_W'(DONE_AT)) tx_done <= 1'b1;
               if (baud_last_c) begin
                  cnt <= '0;
                  if (load_c) begin
                     state  <= S_START;
                     tx_out <= 1'b0;
                  end else if (DE_HOLD_CLKS == 0) begin
                     state    <= S_IDLE;
                     rs485_de <= 1'b0;
                     tx_busy  <= 1'b0;
                  end else begin
                     state <= S_HOLD;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            S_HOLD: begin
               if (load_c) begin
                  state  <= S_START;
                  cnt    <= '0;
                  tx_out <= 1'b0;
               end else if (cnt == CNT_W'(HOLD_LAST)) begin
                  state    <= S_IDLE;
                  cnt      <= '0;
                  rs485_de <= 1'b0;
                  tx_busy  <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            default: begin
               state    <= S_IDLE;
               cnt      <= '0;
               tx_out   <= 1'b1;
               rs485_de <= 1'b0;
               tx_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rs485_tx.sv
// Self-checking bench for rs485_tx: timeline reference model, line decoder and directed timing checks.
module tb_rs485_tx;

   localparam int B = 434;
`ifdef RS485_TX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam int NB        = PAR ? 11 : 10;
   localparam int FRAME     = NB * B;
   localparam int FRAME_LIT = PAR ? 4774 : 4340;
   localparam int SETUP     = 16;
   localparam int HOLD      = 16;
   localparam int LIMIT     = 20000;
   localparam int SEL_OUT   = 0;
   localparam int SEL_DE    = 1;
   localparam int SEL_DONE  = 2;

   logic       sys_clk = 1'b0;
   logic       sys_rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_out;
   logic       rs485_de;
   logic       tx_busy;
   logic       tx_done;

   int checks   = 0;
   int failures = 0;

   rs485_tx #(
      .CLK_FREQ(50_000_000), .BAUD(115_200), .DE_SETUP_CLKS(SETUP), .DE_HOLD_CLKS(HOLD)
   ) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx_out(tx_out), .rs485_de(rs485_de), .tx_busy(tx_busy),
      .tx_done(tx_done)
   );

   always #5 sys_clk = ~sys_clk;

   // Reference model: a transmit session is a timeline position p; [0,s) setup, [s,s+FRAME) frame, then hold.
   int         cyc = 0;
   bit         m_init = 0, m_act = 0, m_full = 0, m_ready = 0;
   int         m_p = 0, m_s = 0;
   logic [7:0] m_buf = '0, m_cur = '0;

   always @(posedge sys_clk) begin
      bit acc, load;
      cyc++;
      if (sys_rst) begin
         m_init = 1; m_act = 0; m_full = 0; m_ready = 0;
      end else begin
         acc  = tx_valid && m_ready;
         load = m_full && (!m_act || m_p >= m_s + FRAME - 1);
         if (m_act) begin
            if (load) begin
               m_p = 0; m_s = 0;
            end else begin
               m_p++;
               if (m_p >= m_s + FRAME + HOLD) m_act = 0;
            end
         end else if (load) begin
            m_act = 1; m_p = 0; m_s = SETUP;
         end
         if (load) begin
            m_cur = m_buf; m_full = 0;
         end
         if (acc) begin
            m_full = 1; m_buf = tx_data;
         end
         m_ready = !m_full;
      end
   end

   function automatic logic model_line();
      int k;
      logic [7:0] sh;
      if (!m_act || m_p < m_s || m_p >= m_s + FRAME) return 1'b1;
      k = (m_p - m_s) / B;
      if (k == 0) return 1'b0;
      if (k <= 8) begin
         sh = m_cur >> (k - 1);
         return sh[0];
      end
      if (PAR && k == 9) return ^m_cur;
      return 1'b1;
   endfunction

   always @(negedge sys_clk) begin
      logic [4:0] got, want;
      if (m_init) begin
         want = {m_ready, model_line(), m_act, m_act, m_act && (m_p == m_s + FRAME - 1)};
         got  = {tx_ready, tx_out, rs485_de, tx_busy, tx_done};
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL cycle_model cyc=%0d got{ready,out,de,busy,done}=%b expected=%b",
                     cyc, got, want);
         end
      end
   end

   // Line decoder: samples mid-bit and matches decoded bytes against accepted bytes in order.
   logic [7:0] dq[$];
   bit         d_act = 0;
   int         d_pos = 0;
   logic [7:0] d_byte = '0;
   logic       d_par = 1'b0;

   always @(negedge sys_clk) begin
      int k;
      logic [7:0] eb;
      if (sys_rst) begin
         d_act = 0;
      end else if (!d_act) begin
         if (tx_out === 1'b0) begin
            d_act = 1; d_pos = 0;
         end
      end else begin
         d_pos++;
         if (d_pos % B == B / 2) begin
            k = d_pos / B;
            if (k >= 1 && k <= 8) begin
               d_byte = {tx_out, d_byte[7:1]};
            end else if (PAR && k == 9) begin
               d_par = tx_out;
            end else if (k == NB - 1) begin
               d_act = 0;
               checks++;
               if (dq.size() == 0) begin
                  failures++;
                  $display("FAIL decode_unexpected got=%h expected=none", d_byte);
               end else begin
                  eb = dq.pop_front();
                  if ({tx_out, d_byte} !== {1'b1, eb}) begin
                     failures++;
                     $display("FAIL decode_byte got=%h stop=%b expected=%h stop=1",
                              d_byte, tx_out, eb);
                  end
`ifdef RS485_TX_PARITY_EN
                  checks++;
                  if (d_par !== ^eb) begin
                     failures++;
                     $display("FAIL decode_parity got=%b expected=%b", d_par, ^eb);
                  end
`endif
               end
            end
         end
      end
   end

   bit watch_de = 0;
   int de_low   = 0;
   always @(negedge sys_clk) if (watch_de && rs485_de !== 1'b1) de_low++;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", nm, got, want);
      end
   endtask

   // Presents a byte and returns at the negedge after the accepting edge.
   task automatic send(input logic [7:0] b, output int t_acc);
      bit ok = 0;
      tx_data  = b;
      tx_valid = 1'b1;
      for (int i = 0; i < LIMIT && !ok; i++) begin
         if (m_ready) ok = 1;
         @(negedge sys_clk);
      end
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
      t_acc    = cyc;
      if (ok) dq.push_back(b);
      else begin
         checks++; failures++;
         $display("FAIL send_timeout got=not_accepted expected=accept byte=%h", b);
      end
   endtask

   task automatic wait_for(input int sel, input logic val, input string nm, output int t);
      bit   hit = 0;
      logic v;
      for (int i = 0; i < LIMIT && !hit; i++) begin
         @(negedge sys_clk);
         case (sel)
            SEL_OUT: v = tx_out;
            SEL_DE:  v = rs485_de;
            default: v = tx_done;
         endcase
         if (v === val) hit = 1;
      end
      t = cyc;
      if (!hit) begin
         checks++; failures++;
         $display("FAIL timeout_%s got=no_event expected=%b", nm, val);
      end
   endtask

   initial begin
      repeat (150000) @(posedge sys_clk);
      $display("FAIL watchdog got=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t_acc, t_acc2, t_de, t_st, t_d, t_d2, t_f, pos, act;
      logic [10:0] pat, sh;

      sys_rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
      repeat (3) @(negedge sys_clk);
      check("rst_tx_out", tx_out, 1);
      check("rst_de", rs485_de, 0);
      check("rst_busy", tx_busy, 0);
      check("rst_done", tx_done, 0);
      check("rst_ready", tx_ready, 0);
      sys_rst = 1'b0;
      @(negedge sys_clk);
      check("ready_after_release", tx_ready, 1);

      // Single byte 0x55
      pat = PAR ? 11'b10010101010 : 11'b01010101010;
      send(8'h55, t_acc);
      wait_for(SEL_DE, 1'b1, "de_rise", t_de);
      check("de_rise_delay", t_de - t_acc, 1);
      wait_for(SEL_OUT, 1'b0, "start", t_st);
      check("setup_len", t_st - t_de, 16);
      pos = 0;
      for (int k = 0; k < NB; k++) begin
         repeat (k * B + B / 2 - pos) @(negedge sys_clk);
         pos = k * B + B / 2;
         sh  = pat >> k;
         check($sformatf("bit55_%0d", k), tx_out, sh[0]);
      end
      wait_for(SEL_DONE, 1'b1, "done", t_d);
      check("done_cycle", t_d - t_st + 1, FRAME_LIT);
      wait_for(SEL_DE, 1'b0, "de_fall", t_f);
      check("hold_len", t_f - t_d - 1, 16);
      check("busy_fall", tx_busy, 0);

      // Back-to-back 0xA5, 0x3C
      repeat (5) @(negedge sys_clk);
      send(8'hA5, t_acc);
      send(8'h3C, t_acc2);
      wait_for(SEL_DE, 1'b1, "b2b_de", t_de);
      de_low = 0; watch_de = 1;
      wait_for(SEL_DONE, 1'b1, "b2b_done1", t_d);
      check("b2b_accept_in_frame1", t_acc2 < t_d, 1);
      @(negedge sys_clk);
      check("b2b_zero_gap", tx_out, 0);
      wait_for(SEL_DONE, 1'b1, "b2b_done2", t_d2);
      check("b2b_done_spacing", t_d2 - t_d, FRAME_LIT);
      watch_de = 0;
      check("b2b_de_continuous", de_low, 0);
      wait_for(SEL_DE, 1'b0, "b2b_idle", t_f);

      // Backpressure with tx_valid held high
      send(8'h11, t_acc);
      send(8'h22, t_acc);
      check("ready_low_holding_22", tx_ready, 0);
      send(8'h33, t_acc);
      wait_for(SEL_DE, 1'b0, "bp_idle", t_f);

      // Byte presented 5 cycles into HOLD
      repeat (3) @(negedge sys_clk);
      send(8'h81, t_acc);
      wait_for(SEL_DE, 1'b1, "hold_de", t_de);
      de_low = 0; watch_de = 1;
      wait_for(SEL_DONE, 1'b1, "hold_done1", t_d);
      repeat (5) @(negedge sys_clk);
      send(8'hC3, t_acc);
      check("hold_still_idle_line", tx_out, 1);
      wait_for(SEL_OUT, 1'b0, "hold_start", t_st);
      check("hold_to_start", t_st - t_acc, 1);
      wait_for(SEL_DONE, 1'b1, "hold_done2", t_d2);
      watch_de = 0;
      check("hold_de_continuous", de_low, 0);
      wait_for(SEL_DE, 1'b0, "hold_idle", t_f);

      // Reset mid-DATA of 0xF0 with 0x0F buffered
      send(8'hF0, t_acc);
      send(8'h0F, t_acc);
      wait_for(SEL_OUT, 1'b0, "rst_start", t_st);
      repeat (3 * B) @(negedge sys_clk);
      sys_rst = 1'b1;
      @(negedge sys_clk);
      check("abort_tx_out", tx_out, 1);
      check("abort_de", rs485_de, 0);
      check("abort_busy", tx_busy, 0);
      check("abort_ready", tx_ready, 0);
      @(negedge sys_clk);
      sys_rst = 1'b0;
      dq.delete();
      @(negedge sys_clk);
      check("abort_ready_release", tx_ready, 1);
      act = 0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge sys_clk);
         if (tx_out !== 1'b1 || rs485_de !== 1'b0) act++;
      end
      check("abort_no_tx", act, 0);

`ifdef RS485_TX_PARITY_EN
      send(8'h07, t_acc);
      wait_for(SEL_OUT, 1'b0, "par07_start", t_st);
      repeat (9 * B + B / 2) @(negedge sys_clk);
      check("parity_07", tx_out, 1);
      wait_for(SEL_DONE, 1'b1, "par07_done", t_d);
      check("parity_frame_len", t_d - t_st + 1, 4774);
      wait_for(SEL_DE, 1'b0, "par07_idle", t_f);
      send(8'h03, t_acc);
      wait_for(SEL_OUT, 1'b0, "par03_start", t_st);
      repeat (9 * B + B / 2) @(negedge sys_clk);
      check("parity_03", tx_out, 0);
      wait_for(SEL_DE, 1'b0, "par03_idle", t_f);
`endif

      // Random bytes with random gaps (idle, hold and back-to-back cases)
      for (int n = 0; n < 3; n++) begin
         repeat ($urandom_range(0, 3000)) @(negedge sys_clk);
         send(8'($urandom), t_acc);
      end
      wait_for(SEL_DE, 1'b0, "rand_idle", t_f);
      repeat (5) @(negedge sys_clk);
      check("all_bytes_decoded", dq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rs485_tx.md
Name: rs485_tx

Overview:
- RS485 byte transmitter: the return path to the STM32, opposite direction to the existing RS485 receive/display chain.
- Accepts bytes from fabric logic over a valid/ready handshake into a one-entry holding buffer.
- Serialises each byte as 8N1 UART, LSB first, on the line driver.
- Drives the transceiver DE pin with programmable setup and hold guard times.

Parameters:
CLK_FREQ, 50_000_000, sys_clk frequency in Hz
BAUD, 115200, line bit rate; BAUD_CNT = CLK_FREQ/BAUD (integer divide, must be >= 2); 434 at defaults
DE_SETUP_CLKS, 16, clocks DE is high before the start bit; 0 skips SETUP
DE_HOLD_CLKS, 16, clocks DE stays high after the last stop bit; 0 skips HOLD

Ports:
sys_clk  input  1  system clock; all logic on rising edge
sys_rst  input  1  synchronous reset, active-high
tx_data  input  8  byte to send
tx_valid  input  1  tx_data valid
tx_ready  output  1  holding buffer empty; a byte is accepted on a cycle with tx_valid & tx_ready
tx_out  output  1  serial line to transceiver DI; idle high
rs485_de  output  1  transceiver driver enable, high = drive bus
tx_busy  output  1  high whenever state != IDLE
tx_done  output  1  one-cycle pulse at the end of each stop bit

Behaviour:
- Reset (sys_rst high at an edge), all registered, effective next edge:
  - state=IDLE, buffer empty, counters 0.
  - tx_out=1, rs485_de=0, tx_busy=0, tx_done=0.
  - tx_ready=0 while sys_rst is high; 1 from the first cycle after release.
- Reset mid-frame aborts: line returns high, DE drops at that edge, any buffered byte is discarded.
- Handshake:
  - Accept on an edge with tx_valid & tx_ready; the byte is latched, buffer full, tx_ready=0 next cycle.
  - tx_data is ignored when not accepted.
  - The buffer empties on the edge the byte is loaded into the shift register; tx_ready=1 the following cycle.
  - A byte can therefore be accepted while the previous frame is still shifting.
- FSM states: IDLE, SETUP, START, DATA, STOP, HOLD (plus PARITY with the option).
- IDLE: tx_out=1, de=0. When the buffer is full: load the shift register, set de=1, then go to SETUP (or START if DE_SETUP_CLKS=0).
- SETUP: lasts DE_SETUP_CLKS cycles, tx_out=1, de=1.
- START: tx_out=0 for BAUD_CNT cycles.
- DATA: 8 bits, LSB first, each bit held BAUD_CNT cycles. A bit counter (0..7) advances on each baud-counter wrap.
- STOP: tx_out=1 for BAUD_CNT cycles; tx_done=1 on the final cycle of STOP.
- Leaving STOP:
  - Buffer full: load the byte and go directly to START. No SETUP, DE stays high, zero idle gap between frames.
  - Buffer empty: go to HOLD (or IDLE if DE_HOLD_CLKS=0).
- HOLD: tx_out=1, de=1 for DE_HOLD_CLKS cycles, then IDLE with de=0.
  - If the buffer fills during HOLD: load and go to START on the next edge; DE stays high.
- Frame timing: the start-bit falling edge to the end of stop is exactly 10*BAUD_CNT cycles (11*BAUD_CNT with parity).
- The baud counter runs 0..BAUD_CNT-1 and resets on every state change.
- tx_out and rs485_de are driven directly from flops, so there are no glitches.
- Simultaneous accept with the end of STOP: the byte accepted on that edge is not yet in the buffer. It is seen in HOLD on the next cycle and goes to START, with DE continuous.

Optional Feature:
- Macro: RS485_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, lasting BAUD_CNT cycles.
  - tx_out carries even parity, the XOR of the 8 data bits.
  - The frame is 11 bits (8E1).
- Undefined: no PARITY state, frame is 8N1, and no parity logic is synthesised.

Test Plan:
- Single byte 0x55 at defaults:
  - DE rises 1 cycle after accept.
  - Start bit begins 16 cycles later.
  - tx_out = 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop), each bit 434 cycles.
  - tx_done pulses at cycle 4340 of the frame.
  - DE falls 16 cycles later and tx_busy falls with it.
- Back-to-back 0xA5 then 0x3C:
  - The second byte is accepted during the first frame.
  - The second start bit immediately follows the first stop bit (0 gap), DE high throughout, two tx_done pulses 4340 cycles apart.
- Backpressure:
  - tx_valid is held high with 0x11, 0x22, 0x33.
  - tx_ready=0 while the buffer holds 0x22.
  - 0x33 is accepted only after 0x22 loads; output order is 0x11, 0x22, 0x33 with no byte lost or duplicated.
- Byte presented 5 cycles into HOLD: START begins the next edge, DE never drops, no SETUP period.
- Reset asserted mid-DATA of 0xF0 with 0x0F buffered: next edge gives tx_out=1, de=0, tx_busy=0; tx_ready=1 after release; 0x0F is never transmitted.
- RS485_TX_PARITY_EN defined:
  - Byte 0x07 gives parity bit 1; byte 0x03 gives parity bit 0.
  - Frame is 4774 cycles and tx_done is at cycle 4774.
